vec_mem_seq: RTL and testbench

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

---
 rtl/vec_mem_pkg.sv | 28 ++
 rtl/vec_addr_gen.sv | 59 +++++
 rtl/vec_mem_seq.sv | 184 ++++++++++++++++++
 tb/tb_vec_mem_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types for the strided vector load/store sequencer.
//   vword_t      : one data-memory word, LANES lanes of LANE_W bits
//   state_t      : sequencer states IDLE / LOAD / STORE / DONE
//   word_in_range: word-index bound check against the highest valid index
package vec_mem_pkg;

   localparam int LANES  = 6;
   localparam int LANE_W = 8;
   localparam int WORD_W = LANES * LANE_W;

   typedef logic [LANES-1:0][LANE_W-1:0] vword_t;

   localparam vword_t VWORD_ZERO = {WORD_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A word index is usable when it does not exceed the highest valid index.
   function automatic logic word_in_range(input logic [29:0] widx,
                                          input logic [29:0] limit);
      return (widx <= limit);
   endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Beat address / beat counter for one strided burst.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch base/count/stride and restart the beat counter
//   step       : one beat has been issued; advance to the next address
//   base       : byte address of beat 0
//   count      : number of beats in the burst
//   stride     : word stride between beats (byte step = stride << 2)
//   addr       : byte address of the current beat
//   last       : the current beat is the final one of the burst
//   exhausted  : every beat of the burst has been issued
module vec_addr_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] base,
   input  logic [4:0]  count,
   input  logic [7:0]  stride,
   output logic [31:0] addr,
   output logic        last,
   output logic        exhausted
);

   logic [31:0] addr_r;
   logic [31:0] stride_bytes_r;
   logic [4:0]  count_r;
   logic [4:0]  issued_r;
   logic        exhausted_s;

   assign exhausted_s = (issued_r == count_r);

   // Burst parameters and running address; the address wraps modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r         <= 32'd0;
         stride_bytes_r <= 32'd0;
         count_r        <= 5'd0;
         issued_r       <= 5'd0;
      end else if (load) begin
         addr_r         <= base;
         stride_bytes_r <= {22'd0, stride, 2'b00};
         count_r        <= count;
         issued_r       <= 5'd0;
      end else if (step && !exhausted_s) begin
         addr_r         <= addr_r + stride_bytes_r;
         issued_r       <= issued_r + 5'd1;
      end else begin
         addr_r         <= addr_r;
         stride_bytes_r <= stride_bytes_r;
         count_r        <= count_r;
         issued_r       <= issued_r;
      end
   end

   assign addr      = addr_r;
   assign exhausted = exhausted_s;
   assign last      = ((issued_r + 5'd1) == count_r);

endmodule

// File: rtl/vec_mem_seq.sv
// Strided vector load/store sequencer in front of a word-addressed data memory.
//   DMEM_SIZE                      : highest valid word index of the memory
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready/req_store  : request handshake, 1 = store, 0 = load
//   req_base/req_count/req_stride  : byte base, beat count (0..16), word stride
//   wd_valid/wd_ready/wd_data      : store data stream, one beat per handshake
//   rd_valid/rd_ready/rd_data      : load data stream, one-deep output register
//   mem_A/mem_WE/mem_WD/mem_RD     : data memory (async read, sync write)
//   busy                           : high in every state except IDLE
//   done                           : one-cycle completion pulse
//   err                            : sticky out-of-range flag, cleared per request
module vec_mem_seq
   import vec_mem_pkg::*;
#(
   parameter int unsigned DMEM_SIZE = 32'd10926
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [31:0] req_base,
   input  logic [4:0]  req_count,
   input  logic [7:0]  req_stride,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  vword_t      wd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output vword_t      rd_data,
   output logic [31:0] mem_A,
   output logic        mem_WE,
   output vword_t      mem_WD,
   input  vword_t      mem_RD,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [29:0] DMEM_LIMIT = DMEM_SIZE[29:0];

   state_t      state_r;
   state_t      state_s;
   logic        rd_valid_r;
   vword_t      rd_data_r;
   logic        err_r;

   logic        load_s;
   logic        step_s;
   logic        issue_s;
   logic        wr_hs_s;
   logic        in_range_s;
   logic [31:0] addr_s;
   logic        last_s;
   logic        exhausted_s;
   logic        out_free_s;

   vec_addr_gen u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .step      (step_s),
      .base      (req_base),
      .count     (req_count),
      .stride    (req_stride),
      .addr      (addr_s),
      .last      (last_s),
      .exhausted (exhausted_s)
   );

   // The full word index is range-checked so high addresses never alias
   // onto valid words of the memory.
   assign in_range_s = word_in_range(addr_s[31:2], DMEM_LIMIT);

   // Output register can take a new beat when empty or drained this cycle.
   assign out_free_s = !rd_valid_r || rd_ready;

   // Next-state and per-cycle beat control.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      issue_s = 1'b0;
      wr_hs_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               load_s = 1'b1;
               if (req_count == 5'd0) begin
                  state_s = DONE;
               end else if (req_store) begin
                  state_s = STORE;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (!exhausted_s && out_free_s) begin
               issue_s = 1'b1;
               step_s  = 1'b1;
            end else if (exhausted_s && out_free_s) begin
               state_s = DONE;
            end else begin
               state_s = LOAD;
            end
         end
         STORE: begin
            if (wd_valid) begin
               wr_hs_s = 1'b1;
               step_s  = 1'b1;
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = STORE;
               end
            end else begin
               state_s = STORE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; a reset mid-burst abandons the burst entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Load output register: capture on issue, hold while stalled, drop on drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= VWORD_ZERO;
      end else if (issue_s) begin
         rd_valid_r <= 1'b1;
         rd_data_r  <= in_range_s ? mem_RD : VWORD_ZERO;
      end else if (rd_ready) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= rd_data_r;
      end else begin
         rd_valid_r <= rd_valid_r;
         rd_data_r  <= rd_data_r;
      end
   end

   // Sticky error: cleared by a new request, set by any out-of-range beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (load_s) begin
         err_r <= 1'b0;
      end else if ((issue_s || wr_hs_s) && !in_range_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign req_ready = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign wd_ready  = (state_r == STORE);
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;
   assign err       = err_r;

   // The memory sees an address only on an issued load beat or while storing.
   assign mem_A  = (issue_s || (state_r == STORE)) ? addr_s : 32'd0;
   assign mem_WE = wr_hs_s && in_range_s;
   assign mem_WD = (state_r == STORE) ? wd_data : VWORD_ZERO;

endmodule

// File: tb/tb_vec_mem_seq.sv
module tb_vec_mem_seq;
   import vec_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_store;
   logic [31:0] req_base;
   logic [4:0]  req_count;
   logic [7:0]  req_stride;
   logic        wd_valid, wd_ready;
   vword_t      wd_data;
   logic        rd_valid, rd_ready;
   vword_t      rd_data;
   logic [31:0] mem_A;
   logic        mem_WE;
   vword_t      mem_WD, mem_RD;
   logic        busy, done, err;

   int n_checks = 0;
   int n_err    = 0;

   vword_t tbmem  [0:16383];
   vword_t exp_mem[0:16383];
   logic   mem_init_r = 1'b0;

   typedef struct {
      logic        st;
      logic [31:0] base;
      logic [4:0]  cnt;
      logic [7:0]  stride;
      int          exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vt[9];

   vec_mem_seq #(.DMEM_SIZE(32'd10926)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_base(req_base), .req_count(req_count), .req_stride(req_stride),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic vword_t pat(input int w);
      vword_t v;
      v[0] = 8'(w);
      v[1] = 8'(w >> 8) | 8'h80;
      for (int l = 2; l < LANES; l++) v[l] = 8'(192 + l);
      return v;
   endfunction

   function automatic vword_t wdat(input int tag, input int k);
      vword_t v;
      for (int l = 0; l < LANES; l++) v[l] = 8'(tag * 16 + k * 6 + l);
      return v;
   endfunction

   function automatic logic [31:0] ea(input logic [31:0] b, input logic [7:0] s, input int k);
      return b + 32'(k) * {22'd0, s, 2'b00};
   endfunction

   function automatic logic in_rng(input logic [31:0] a);
      return (a[31:2] <= 30'd10926);
   endfunction

   // Memory model: async read, write on rising edge, preloaded on first edge.
   assign mem_RD = tbmem[mem_A[15:2]];
   always @(posedge clk) begin
      if (!mem_init_r) begin
         for (int w = 0; w < 16384; w++) tbmem[w] <= pat(w);
         mem_init_r <= 1'b1;
      end else if (mem_WE) begin
         tbmem[mem_A[15:2]] <= mem_WD;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_mem_WE"}, 64'(mem_WE), 64'd0);
      chk({tag, "_mem_A"}, 64'(mem_A), 64'd0);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input int tag);
      int k;
      logic got_done;
      logic [31:0] a;
      logic inr;
      vword_t d;
      k = 0;
      got_done = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = v.st; req_base = v.base;
      req_count = v.cnt; req_stride = v.stride;
      wd_valid = v.st; wd_data = wdat(tag, 0); rd_ready = 1'b1;
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
         @(negedge clk);
         chk("busy", 64'(busy), 64'd1);
         a = ea(v.base, v.stride, k);
         inr = in_rng(a);
         if (done) begin
            got_done = 1'b1;
            chk("done_cycle", 64'(cyc), 64'(v.exp_done));
            chk("err_at_done", 64'(err), 64'(v.exp_err));
            chk("done_mem_A", 64'(mem_A), 64'd0);
            chk("done_mem_WE", 64'(mem_WE), 64'd0);
         end else if (v.st) begin
            if (wd_ready && wd_valid) begin
               chk("st_addr", 64'(mem_A), 64'(a));
               chk("st_we", 64'(mem_WE), 64'(inr));
               chk("st_wd", 64'(mem_WD), 64'(wd_data));
               if (inr) exp_mem[a[15:2]] = wd_data;
               k++;
            end else begin
               chk("st_wd_ready", 64'(wd_ready), 64'd1);
            end
         end else begin
            chk("ld_we", 64'(mem_WE), 64'd0);
            if (cyc <= int'(v.cnt)) chk("ld_addr", 64'(mem_A), 64'(ea(v.base, v.stride, cyc - 1)));
            else chk("ld_addr_quiet", 64'(mem_A), 64'd0);
            if (rd_valid) begin
               d = inr ? exp_mem[a[15:2]] : VWORD_ZERO;
               chk("ld_data", 64'(rd_data), 64'(d));
               k++;
            end
         end
         @(posedge clk); #1;
         wd_data = wdat(tag, k);
      end
      wd_valid = 1'b0;
      chk("done_seen", 64'(got_done), 64'd1);
      chk("beats", 64'(k), 64'(v.cnt));
      @(negedge clk);
      chk("done_pulse_end", 64'(done), 64'd0);
      chk("busy_end", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [1:0] wv [4];
      logic [31:0] sa [3];
      vword_t e0, e1;
      int k;

      vt[0] = '{1'b0, 32'h0000_0010, 5'd4,  8'd1,   6,  1'b0};
      vt[1] = '{1'b1, 32'h0000_0100, 5'd5,  8'd3,   6,  1'b0};
      vt[2] = '{1'b0, 32'h0000_0100, 5'd5,  8'd3,   7,  1'b0};
      vt[3] = '{1'b0, 32'hFFFF_FFF8, 5'd3,  8'd1,   5,  1'b1};
      vt[4] = '{1'b1, 32'h0000_0000, 5'd0,  8'd0,   1,  1'b0};
      vt[5] = '{1'b0, 32'h0000_0000, 5'd16, 8'd255, 18, 1'b0};
      vt[6] = '{1'b1, 32'h0000_0004, 5'd1,  8'd0,   2,  1'b0};
      vt[7] = '{1'b0, 32'h0000_0004, 5'd3,  8'd0,   5,  1'b0};
      vt[8] = '{1'b0, 32'h0000_0040, 5'd0,  8'd2,   1,  1'b0};

      for (int w = 0; w < 16384; w++) exp_mem[w] = pat(w);

      rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_base = 32'd0;
      req_count = 5'd0; req_stride = 8'd0; wd_valid = 1'b0; wd_data = VWORD_ZERO;
      rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("por");
      rst_n = 1'b1;

      // Store with wd_valid gaps: writes only on handshake cycles.
      wv[0] = 2'd1; wv[1] = 2'd0; wv[2] = 2'd1; wv[3] = 2'd1;
      sa[0] = 32'h0; sa[1] = 32'h8; sa[2] = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = 1'b1; req_base = 32'h0; req_count = 5'd3; req_stride = 8'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         wd_valid = wv[c][0];
         wd_data = wdat(9, k);
         @(negedge clk);
         chk("gap_we", 64'(mem_WE), 64'(wv[c][0]));
         chk("gap_addr", 64'(mem_A), 64'(sa[k]));
         if (wv[c][0]) begin
            exp_mem[sa[k][15:2]] = wd_data;
            k++;
         end
         @(posedge clk); #1;
      end
      wd_valid = 1'b0;
      @(negedge clk);
      chk("gap_done", 64'(done), 64'd1);
      chk("gap_err", 64'(err), 64'd0);

      for (int i = 0; i < 9; i++) run_vec(vt[i], i);

      // Store across the top of memory; err sticks until the next request.
      begin
         vec_t vs, vl;
         vs = '{1'b1, 32'h0000_AAB8, 5'd2, 8'd1, 3, 1'b1};
         vl = '{1'b0, 32'h0000_AAB0, 5'd3, 8'd1, 5, 1'b0};
         run_vec(vs, 10);
         repeat (3) @(negedge clk);
         chk("err_sticky", 64'(err), 64'd1);
         chk("err_sticky_idle", 64'(busy), 64'd0);
         run_vec(vl, 11);
      end

      // Load stalled by rd_ready=0; a request while busy is ignored.
      e0 = exp_mem[8];
      e1 = exp_mem[9];
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = 1'b0; req_base = 32'h20; req_count = 5'd2;
      req_stride = 8'd1; rd_ready = 1'b0;
      @(posedge clk); #1;
      req_store = 1'b1; req_base = 32'h300; req_count = 5'd7;
      @(negedge clk);
      chk("stall_a0", 64'(mem_A), 64'h20);
      chk("stall_v0", 64'(rd_valid), 64'd0);
      for (int c = 2; c <= 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("stall_valid", 64'(rd_valid), 64'd1);
         chk("stall_data", 64'(rd_data), 64'(e0));
         chk("stall_noissue", 64'(mem_A), 64'd0);
         chk("stall_we", 64'(mem_WE), 64'd0);
      end
      @(posedge clk); #1;
      rd_ready = 1'b1;
      @(negedge clk);
      chk("stall_a1", 64'(mem_A), 64'h24);
      chk("stall_data0", 64'(rd_data), 64'(e0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_data1", 64'(rd_data), 64'(e1));
      chk("stall_valid1", 64'(rd_valid), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_done", 64'(done), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("stall_idle", 64'(busy), 64'd0);
      chk("stall_no_store", 64'(mem_WE), 64'd0);

      // Reset in the middle of a 5-beat load.
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = 1'b0; req_base = 32'hFFFF_FFFC; req_count = 5'd5;
      req_stride = 8'd2; rd_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre_a0", 64'(mem_A), 64'hFFFF_FFFC);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_a1", 64'(mem_A), 64'h4);
      chk("rst_pre_err", 64'(err), 64'd1);
      chk("rst_pre_valid", 64'(rd_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset("rst_mid");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("post_rst_A", 64'(mem_A), 64'd0);
         chk("post_rst_WE", 64'(mem_WE), 64'd0);
         chk("post_rst_busy", 64'(busy), 64'd0);
         chk("post_rst_valid", 64'(rd_valid), 64'd0);
         chk("post_rst_done", 64'(done), 64'd0);
      end

      run_vec(vt[0], 12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
